gpu_mem_arbiter: RTL and testbench

Parametrised shared-memory block for the GPU: an N-port arbitrated single-port data RAM that replaces the fixed-width shared memory between the Core array and memory. Each core port issues one read or write at a time and gets a one-cycle `ready` pulse on completion. A VGA scan port takes absolute priority while `vga_en` is high. Arbitration among cores is selectable between round-robin and fixed priority.

---
 rtl/gpu_mem_arbiter_if.sv | 25 ++
 rtl/gpu_mem_arbiter.sv | 111 +++++++++++
 tb/tb_gpu_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_mem_arbiter_if.sv
// Core-port and VGA-port bundle for the shared-memory arbiter.
// Lane i owns enable[i], addr[i], wr_data[i], rd_data[i], ready[i].
interface gpu_mem_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_SIZE = 8,
    parameter int REG_SIZE  = 8
);
    logic [NUM_PORTS-1:0][1:0]           enable;
    logic [NUM_PORTS-1:0][ADDR_SIZE-1:0] addr;
    logic [NUM_PORTS-1:0][REG_SIZE-1:0]  wr_data;
    logic [NUM_PORTS-1:0][REG_SIZE-1:0]  rd_data;
    logic [NUM_PORTS-1:0]                ready;
    logic                                vga_en;
    logic [ADDR_SIZE-1:0]                vga_addr;
    logic [REG_SIZE-1:0]                 vga_data;

    modport master (
        output enable, addr, wr_data, vga_en, vga_addr,
        input  rd_data, ready, vga_data
    );
    modport slave (
        input  enable, addr, wr_data, vga_en, vga_addr,
        output rd_data, ready, vga_data
    );
endinterface

// File: rtl/gpu_mem_arbiter.sv
// N-port arbitrated single-port RAM with a VGA scan port that preempts all cores.
// One access per cycle; a granted core sees ready (and read data) the next cycle.
module gpu_mem_arbiter_lane #(
    parameter int REG_SIZE = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                gnt,
    input  logic                rd,
    input  logic [REG_SIZE-1:0] ram_rdata,
    output logic                ready,
    output logic [REG_SIZE-1:0] rd_data
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready   <= 1'b0;
            rd_data <= '0;
        end else begin
            ready <= gnt;
            if (gnt && rd) rd_data <= ram_rdata;
        end
    end
endmodule

module gpu_mem_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_SIZE = 8,
    parameter int REG_SIZE  = 8,
    parameter int ARB_MODE  = 0
) (
    input  logic            clk,
    input  logic            reset,
    gpu_mem_arbiter_if.slave bus
);
    localparam int PW    = $clog2(NUM_PORTS);
    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [REG_SIZE-1:0]                mem [DEPTH];
    logic [NUM_PORTS-1:0]               req, is_rd, elig, gnt, ready_q;
    logic [NUM_PORTS-1:0][REG_SIZE-1:0] rd_q;
    logic [PW-1:0]                      rr_ptr, base, win;
    logic [PW:0]                        idx;
    logic                               found, gnt_vld, wr_en;
    logic [ADDR_SIZE-1:0]               ram_addr;
    logic [REG_SIZE-1:0]                ram_rdata, vga_q;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            is_rd[i] = (bus.enable[i] == 2'b01);
            req[i]   = is_rd[i] || (bus.enable[i] == 2'b10);
        end
    end

    // A port seeing its completion is held off for that cycle.
    assign elig = req & ~ready_q;

    always_comb begin
        base  = (ARB_MODE == 0) ? rr_ptr : '0;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (PW+1)'(k) + {1'b0, base};
            if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
            if (!found && elig[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    assign gnt_vld = found && !bus.vga_en;

    always_comb begin
        gnt      = '0;
        gnt[win] = gnt_vld;
    end

    assign wr_en     = gnt_vld && !is_rd[win];
    assign ram_addr  = bus.vga_en ? bus.vga_addr : bus.addr[win];
    assign ram_rdata = mem[ram_addr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[ram_addr] <= bus.wr_data[win];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            vga_q  <= '0;
        end else begin
            if (bus.vga_en) vga_q <= ram_rdata;
            if (ARB_MODE == 0 && gnt_vld)
                rr_ptr <= (win == PW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
        end
    end

    gpu_mem_arbiter_lane #(.REG_SIZE(REG_SIZE)) u_lane [NUM_PORTS-1:0] (
        .clk       (clk),
        .reset     (reset),
        .gnt       (gnt),
        .rd        (is_rd),
        .ram_rdata (ram_rdata),
        .ready     (ready_q),
        .rd_data   (rd_q)
    );

    assign bus.ready    = ready_q;
    assign bus.rd_data  = rd_q;
    assign bus.vga_data = vga_q;
endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed bench: round-robin 4-port, fixed-priority 4-port and 3-port/4-bit-address instances.
module tb_gpu_mem_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gpu_mem_arbiter_if #(.NUM_PORTS(4), .ADDR_SIZE(8), .REG_SIZE(8)) b_rr ();
    gpu_mem_arbiter_if #(.NUM_PORTS(4), .ADDR_SIZE(8), .REG_SIZE(8)) b_fx ();
    gpu_mem_arbiter_if #(.NUM_PORTS(3), .ADDR_SIZE(4), .REG_SIZE(8)) b_w ();

    gpu_mem_arbiter #(.NUM_PORTS(4), .ADDR_SIZE(8), .REG_SIZE(8), .ARB_MODE(0))
        u_rr (.clk(clk), .reset(reset), .bus(b_rr));
    gpu_mem_arbiter #(.NUM_PORTS(4), .ADDR_SIZE(8), .REG_SIZE(8), .ARB_MODE(1))
        u_fx (.clk(clk), .reset(reset), .bus(b_fx));
    gpu_mem_arbiter #(.NUM_PORTS(3), .ADDR_SIZE(4), .REG_SIZE(8), .ARB_MODE(0))
        u_w (.clk(clk), .reset(reset), .bus(b_w));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b_rr.enable = '0; b_rr.addr = '0; b_rr.wr_data = '0; b_rr.vga_en = 1'b0; b_rr.vga_addr = '0;
        b_fx.enable = '0; b_fx.addr = '0; b_fx.wr_data = '0; b_fx.vga_en = 1'b0; b_fx.vga_addr = '0;
        b_w.enable  = '0; b_w.addr  = '0; b_w.wr_data  = '0; b_w.vga_en  = 1'b0; b_w.vga_addr  = '0;
    endtask

    task automatic rr_write(input int p, input logic [7:0] a, input logic [7:0] d);
        b_rr.enable[p]  = 2'b10;
        b_rr.addr[p]    = a;
        b_rr.wr_data[p] = d;
        tick();
        b_rr.enable[p]  = 2'b00;
        tick();
    endtask

    task automatic test_reset();
        rr_write(1, 8'h30, 8'h33);
        b_rr.enable[1] = 2'b01;
        b_rr.addr[1]   = 8'h30;
        tick();
        checks++;
        if (b_rr.ready !== 4'b0010) begin errors++; $display("FAIL rst_pre_ready got %b exp %b", b_rr.ready, 4'b0010); end
        checks++;
        if (b_rr.rd_data[1] !== 8'h33) begin errors++; $display("FAIL rst_pre_rd got %h exp %h", b_rr.rd_data[1], 8'h33); end
        b_rr.enable[1] = 2'b00;
        b_rr.vga_en    = 1'b1;
        b_rr.vga_addr  = 8'h30;
        tick();
        checks++;
        if (b_rr.vga_data !== 8'h33) begin errors++; $display("FAIL rst_pre_vga got %h exp %h", b_rr.vga_data, 8'h33); end
        b_rr.vga_en     = 1'b0;
        // a write in flight when reset drops must never complete
        b_rr.enable[2]  = 2'b10;
        b_rr.addr[2]    = 8'h31;
        b_rr.wr_data[2] = 8'hEE;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (b_rr.ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp %b", b_rr.ready, 4'b0000); end
        checks++;
        if (b_rr.rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd_data got %h exp %h", b_rr.rd_data, 32'h0); end
        checks++;
        if (b_rr.vga_data !== 8'h00) begin errors++; $display("FAIL rst_vga got %h exp %h", b_rr.vga_data, 8'h00); end
        checks++;
        if (b_fx.ready !== 4'b0000 || b_w.ready !== 3'b000) begin
            errors++; $display("FAIL rst_other_ready got %b/%b exp 0000/000", b_fx.ready, b_w.ready);
        end
        b_rr.enable[2] = 2'b00;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (b_rr.ready !== 4'b0000) begin errors++; $display("FAIL rst_discard got %b exp %b", b_rr.ready, 4'b0000); end
    endtask

    task automatic test_single_access();
        b_rr.enable[0]  = 2'b10;
        b_rr.addr[0]    = 8'h10;
        b_rr.wr_data[0] = 8'hA5;
        #1;
        checks++;
        if (b_rr.ready !== 4'b0000) begin errors++; $display("FAIL sa_wr_pre got %b exp %b", b_rr.ready, 4'b0000); end
        tick();
        checks++;
        if (b_rr.ready !== 4'b0001) begin errors++; $display("FAIL sa_wr_ready got %b exp %b", b_rr.ready, 4'b0001); end
        checks++;
        if (b_rr.rd_data[0] !== 8'h00) begin errors++; $display("FAIL sa_wr_no_rd got %h exp %h", b_rr.rd_data[0], 8'h00); end
        b_rr.enable[0] = 2'b00;
        tick();
        checks++;
        if (b_rr.ready !== 4'b0000) begin errors++; $display("FAIL sa_wr_drop got %b exp %b", b_rr.ready, 4'b0000); end
        b_rr.enable[0] = 2'b01;
        tick();
        checks++;
        if (b_rr.ready !== 4'b0001) begin errors++; $display("FAIL sa_rd_ready got %b exp %b", b_rr.ready, 4'b0001); end
        checks++;
        if (b_rr.rd_data[0] !== 8'hA5) begin errors++; $display("FAIL sa_rd_data got %h exp %h", b_rr.rd_data[0], 8'hA5); end
        // request still held through the completion cycle: masked, no regrant
        tick();
        checks++;
        if (b_rr.ready !== 4'b0000) begin errors++; $display("FAIL sa_rd_pulse got %b exp %b", b_rr.ready, 4'b0000); end
        checks++;
        if (b_rr.rd_data[0] !== 8'hA5) begin errors++; $display("FAIL sa_rd_hold got %h exp %h", b_rr.rd_data[0], 8'hA5); end
        b_rr.enable[0] = 2'b00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        for (int i = 0; i < 5; i++) rr_write(0, 8'(i), 8'(i));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            b_rr.enable[p] = 2'b01;
            b_rr.addr[p]   = 8'(p + 1);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_rdy = 4'b0001 << (k % 4);
            checks++;
            if (b_rr.ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, b_rr.ready, exp_rdy); end
            checks++;
            if (b_rr.rd_data[k % 4] !== 8'(k % 4 + 1)) begin
                errors++; $display("FAIL rr_data[%0d] got %h exp %h", k, b_rr.rd_data[k % 4], 8'(k % 4 + 1));
            end
        end
        b_rr.enable = '0;
    endtask

    task automatic test_vga();
        b_rr.enable[2] = 2'b01;
        b_rr.addr[2]   = 8'h03;
        tick();
        checks++;
        if (b_rr.ready !== 4'b0100) begin errors++; $display("FAIL vga_prior_ready got %b exp %b", b_rr.ready, 4'b0100); end
        for (int p = 0; p < 4; p++) begin
            b_rr.enable[p] = 2'b01;
            b_rr.addr[p]   = 8'(p + 1);
        end
        b_rr.vga_en   = 1'b1;
        b_rr.vga_addr = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (b_rr.vga_data !== 8'(k)) begin errors++; $display("FAIL vga_data[%0d] got %h exp %h", k, b_rr.vga_data, 8'(k)); end
            checks++;
            if (b_rr.ready !== 4'b0000) begin errors++; $display("FAIL vga_block[%0d] got %b exp %b", k, b_rr.ready, 4'b0000); end
            b_rr.vga_addr = 8'(k + 1);
        end
        b_rr.vga_en = 1'b0;
        // pointer sits after port 2, so port 3 resumes first
        tick();
        checks++;
        if (b_rr.ready !== 4'b1000) begin errors++; $display("FAIL vga_resume got %b exp %b", b_rr.ready, 4'b1000); end
        checks++;
        if (b_rr.vga_data !== 8'h04) begin errors++; $display("FAIL vga_hold got %h exp %h", b_rr.vga_data, 8'h04); end
        tick();
        checks++;
        if (b_rr.ready !== 4'b0001) begin errors++; $display("FAIL vga_resume_wrap got %b exp %b", b_rr.ready, 4'b0001); end
        b_rr.enable = '0;
        tick();
    endtask

    task automatic test_fixed_priority();
        logic [3:0] exp_rdy;
        b_fx.enable[0] = 2'b10; b_fx.addr[0] = 8'h50; b_fx.wr_data[0] = 8'h50;
        b_fx.enable[2] = 2'b10; b_fx.addr[2] = 8'h52; b_fx.wr_data[2] = 8'h52;
        b_fx.enable[3] = 2'b10; b_fx.addr[3] = 8'h53; b_fx.wr_data[3] = 8'h53;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            checks++;
            if (b_fx.ready !== exp_rdy) begin errors++; $display("FAIL fx_ready[%0d] got %b exp %b", k, b_fx.ready, exp_rdy); end
        end
        b_fx.enable = '0;
        tick();
        b_fx.enable[1] = 2'b01;
        b_fx.addr[1]   = 8'h50;
        tick();
        checks++;
        if (b_fx.ready !== 4'b0010) begin errors++; $display("FAIL fx_rd_ready got %b exp %b", b_fx.ready, 4'b0010); end
        checks++;
        if (b_fx.rd_data[1] !== 8'h50) begin errors++; $display("FAIL fx_rd_data got %h exp %h", b_fx.rd_data[1], 8'h50); end
        b_fx.enable = '0;
        tick();
    endtask

    task automatic test_wrap();
        b_w.enable[1]  = 2'b10;
        b_w.addr[1]    = 4'hF;
        b_w.wr_data[1] = 8'h3C;
        tick();
        checks++;
        if (b_w.ready !== 3'b010) begin errors++; $display("FAIL wrap_wr_ready got %b exp %b", b_w.ready, 3'b010); end
        b_w.enable[1] = 2'b00;
        b_w.enable[0] = 2'b01; b_w.addr[0] = 4'hF;
        b_w.enable[2] = 2'b01; b_w.addr[2] = 4'hF;
        tick();
        checks++;
        if (b_w.ready !== 3'b100) begin errors++; $display("FAIL wrap_p2_ready got %b exp %b", b_w.ready, 3'b100); end
        checks++;
        if (b_w.rd_data[2] !== 8'h3C) begin errors++; $display("FAIL wrap_p2_data got %h exp %h", b_w.rd_data[2], 8'h3C); end
        tick();
        checks++;
        if (b_w.ready !== 3'b001) begin errors++; $display("FAIL wrap_p0_ready got %b exp %b", b_w.ready, 3'b001); end
        checks++;
        if (b_w.rd_data[0] !== 8'h3C) begin errors++; $display("FAIL wrap_p0_data got %h exp %h", b_w.rd_data[0], 8'h3C); end
        b_w.enable = '0;
        tick();
    endtask

    initial begin
        idle_all();
        tick();
        tick();
        reset = 1'b1;
        tick();
        test_reset();
        test_single_access();
        test_round_robin();
        test_vga();
        test_fixed_priority();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
